// File: rtl/rake_mrc_sched.sv
// RAKE maximal-ratio combiner: one shared pipelined complex multiplier,
// one finger issued per cycle, products accumulated as they return.
module rake_mrc_sched #(
    parameter int NUM_FINGERS = 3,
    parameter int W           = 16,
    parameter int MULT_LAT    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_FINGERS*W-1:0] x_r,
    input  logic [NUM_FINGERS*W-1:0] x_i,
    input  logic [NUM_FINGERS*W-1:0] c_r,
    input  logic [NUM_FINGERS*W-1:0] c_i,
    input  logic [NUM_FINGERS-1:0]   finger_en,
    output logic [W-1:0]             m_ar,
    output logic [W-1:0]             m_ai,
    output logic [W-1:0]             m_br,
    output logic [W-1:0]             m_bi,
    output logic                     m_ce,
    input  logic [W-1:0]             m_pr,
    input  logic [W-1:0]             m_pi,
    output logic [W-1:0]             y_r,
    output logic [W-1:0]             y_i,
    output logic                     y_valid,
    output logic                     y_sat
);

    localparam int NW = NUM_FINGERS * W;
    localparam int AW = W + $clog2(NUM_FINGERS) + 1;
    localparam int IW = (NUM_FINGERS > 1) ? $clog2(NUM_FINGERS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_FINGERS - 1);
    localparam logic signed [AW-1:0] AMAX =
        {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] AMIN = ~AMAX;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NW-1:0]          xr_q, xr_d, xi_q, xi_d;
    logic [NW-1:0]          cr_q, cr_d, ci_q, ci_d;
    logic [NUM_FINGERS-1:0] en_q, en_d;
    logic [MULT_LAT-1:0]    tag_q, tag_d;
    logic signed [AW-1:0]   accr_q, accr_d, acci_q, acci_d;
    logic [W-1:0]           yr_q, yr_d, yi_q, yi_d;
    logic                   ysat_q, ysat_d;
    logic                   tag_in;
    logic [W:0]             sr, si;

    // Returns {clipped, saturated value}.
    function automatic logic [W:0] sat(input logic signed [AW-1:0] a);
        if (a > AMAX)
            return {1'b1, 1'b0, {(W-1){1'b1}}};
        else if (a < AMIN)
            return {1'b1, 1'b1, {(W-1){1'b0}}};
        else
            return {1'b0, a[W-1:0]};
    endfunction

    assign tag_in = (state_q == ISSUE);
    assign tag_d  = (tag_q << 1) | MULT_LAT'(tag_in);

    assign y_r   = yr_q;
    assign y_i   = yi_q;
    assign y_sat = ysat_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        xr_d     = xr_q;
        xi_d     = xi_q;
        cr_d     = cr_q;
        ci_d     = ci_q;
        en_d     = en_q;
        accr_d   = accr_q;
        acci_d   = acci_q;
        yr_d     = yr_q;
        yi_d     = yi_q;
        ysat_d   = ysat_q;
        sr       = '0;
        si       = '0;
        in_ready = 1'b0;
        m_ce     = 1'b0;
        m_ar     = '0;
        m_ai     = '0;
        m_br     = '0;
        m_bi     = '0;
        y_valid  = 1'b0;

        if (tag_q[MULT_LAT-1]) begin
            accr_d = accr_q + $signed({{(AW-W){m_pr[W-1]}}, m_pr});
            acci_d = acci_q + $signed({{(AW-W){m_pi[W-1]}}, m_pi});
        end

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    xr_d    = x_r;
                    xi_d    = x_i;
                    cr_d    = c_r;
                    ci_d    = c_i;
                    en_d    = finger_en;
                    accr_d  = '0;
                    acci_d  = '0;
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                m_ce = 1'b1;
                // Disabled finger still occupies its slot: fixed latency.
                if (en_q[idx_q]) begin
                    m_ar = xr_q[idx_q*W +: W];
                    m_ai = xi_q[idx_q*W +: W];
                end
                m_br = cr_q[idx_q*W +: W];
                m_bi = ci_q[idx_q*W +: W];
                if (idx_q == LAST)
                    state_d = DRAIN;
                else
                    idx_d = idx_q + 1'b1;
            end
            DRAIN: begin
                m_ce = 1'b1;
                if (tag_d == '0) begin
                    state_d = DONE;
                    sr      = sat(accr_d);
                    si      = sat(acci_d);
                    yr_d    = sr[W-1:0];
                    yi_d    = si[W-1:0];
                    ysat_d  = sr[W] | si[W];
                end
            end
            DONE: begin
                y_valid = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            xr_q    <= '0;
            xi_q    <= '0;
            cr_q    <= '0;
            ci_q    <= '0;
            en_q    <= '0;
            tag_q   <= '0;
            accr_q  <= '0;
            acci_q  <= '0;
            yr_q    <= '0;
            yi_q    <= '0;
            ysat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            xr_q    <= xr_d;
            xi_q    <= xi_d;
            cr_q    <= cr_d;
            ci_q    <= ci_d;
            en_q    <= en_d;
            tag_q   <= tag_d;
            accr_q  <= accr_d;
            acci_q  <= acci_d;
            yr_q    <= yr_d;
            yi_q    <= yi_d;
            ysat_q  <= ysat_d;
        end
    end

endmodule

// File: tb/tb_rake_mrc_sched.sv
// Directed bench for rake_mrc_sched with a behavioural pipelined
// complex multiplier (product = A*B, truncated to W bits).
module tb_rake_mrc_sched;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int L  = 4;
    localparam int NW = N * W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NW-1:0] x_r = '0, x_i = '0, c_r = '0, c_i = '0;
    logic [N-1:0]  finger_en = '0;
    logic [W-1:0]  m_ar, m_ai, m_br, m_bi, m_pr, m_pi;
    logic          m_ce;
    logic [W-1:0]  y_r, y_i;
    logic          y_valid, y_sat;

    int n_chk  = 0;
    int n_fail = 0;

    rake_mrc_sched #(.NUM_FINGERS(N), .W(W), .MULT_LAT(L)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_r(x_r), .x_i(x_i), .c_r(c_r), .c_i(c_i),
        .finger_en(finger_en),
        .m_ar(m_ar), .m_ai(m_ai), .m_br(m_br), .m_bi(m_bi),
        .m_ce(m_ce), .m_pr(m_pr), .m_pi(m_pi),
        .y_r(y_r), .y_i(y_i), .y_valid(y_valid), .y_sat(y_sat)
    );

    always #5 clk = ~clk;

    logic [W-1:0] pr_pipe [L];
    logic [W-1:0] pi_pipe [L];
    logic signed [2*W-1:0] full_r, full_i;

    always_comb begin
        full_r = $signed(m_ar) * $signed(m_br) - $signed(m_ai) * $signed(m_bi);
        full_i = $signed(m_ar) * $signed(m_bi) + $signed(m_ai) * $signed(m_br);
    end

    always @(posedge clk) begin
        if (m_ce) begin
            pr_pipe[0] <= full_r[W-1:0];
            pi_pipe[0] <= full_i[W-1:0];
            for (int s = 1; s < L; s++) begin
                pr_pipe[s] <= pr_pipe[s-1];
                pi_pipe[s] <= pi_pipe[s-1];
            end
        end
    end

    assign m_pr = pr_pipe[L-1];
    assign m_pi = pi_pipe[L-1];

    typedef struct {
        logic [N-1:0]  en;
        logic [NW-1:0] xr, xi, cr, ci;
        logic [W-1:0]  yr, yi;
        logic          sat;
    } vec_t;

    vec_t tv [7];

    function automatic logic [NW-1:0] p3(input int a0, input int a1, input int a2);
        return {16'(a2), 16'(a1), 16'(a0)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int v);
        x_r       = tv[v].xr;
        x_i       = tv[v].xi;
        c_r       = tv[v].cr;
        c_i       = tv[v].ci;
        finger_en = tv[v].en;
        in_valid  = 1'b1;
    endtask

    // mode 0: plain, 1: keep in_valid high with vector nxt, 2: scramble inputs
    task automatic run_symbol(input int v, input int mode, input int nxt);
        logic [63:0] eop;
        logic [W-1:0] ear, eai;
        int k;
        drive(v);
        chk("in_ready_idle", in_ready, 1);
        for (int c = 1; c <= N + L + 1; c++) begin
            step();
            if (c == 1) begin
                if (mode == 1) drive(nxt);
                else in_valid = 1'b0;
            end
            if (mode == 2) begin
                if (c <= N + L) begin
                    in_valid  = 1'($urandom_range(0, 1));
                    x_r       = 48'({$urandom(), $urandom()});
                    x_i       = 48'({$urandom(), $urandom()});
                    c_r       = 48'({$urandom(), $urandom()});
                    c_i       = 48'({$urandom(), $urandom()});
                    finger_en = 3'($urandom());
                end else begin
                    in_valid = 1'b0;
                end
            end
            chk("in_ready_busy", in_ready, 0);
            chk("m_ce", m_ce, 64'(c <= N + L));
            chk("y_valid", y_valid, 64'(c == N + L + 1));
            if (c <= N) begin
                k   = c - 1;
                ear = tv[v].en[k] ? tv[v].xr[k*W +: W] : '0;
                eai = tv[v].en[k] ? tv[v].xi[k*W +: W] : '0;
                eop = {ear, eai, tv[v].cr[k*W +: W], tv[v].ci[k*W +: W]};
                chk("issue_operands", {m_ar, m_ai, m_br, m_bi}, eop);
            end else if (c <= N + L) begin
                chk("drain_operands", {m_ar, m_ai, m_br, m_bi}, 64'h0);
            end
        end
        chk("y_r", y_r, tv[v].yr);
        chk("y_i", y_i, tv[v].yi);
        chk("y_sat", y_sat, tv[v].sat);
        step();
        chk("y_hold", {y_valid, y_r, y_i}, {1'b0, tv[v].yr, tv[v].yi});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0] = '{3'b111, p3(100, 200, -50), p3(10, -20, 5),
                  p3(1, 1, 1), p3(0, 0, 0), 16'd250, -16'sd5, 1'b0};
        tv[1] = '{3'b010, p3(100, 200, -50), p3(10, -20, 5),
                  p3(1, 1, 1), p3(0, 0, 0), 16'd200, -16'sd20, 1'b0};
        tv[2] = '{3'b111, p3(20000, 20000, 20000), p3(-20000, -20000, -20000),
                  p3(1, 1, 1), p3(0, 0, 0), 16'h7fff, 16'h8000, 1'b1};
        tv[3] = '{3'b111, p3(3, 5, 7), p3(4, -6, 8),
                  p3(0, 0, 0), p3(1, 1, 1), -16'sd6, 16'd15, 1'b0};
        tv[4] = '{3'b000, p3(100, 200, -50), p3(10, -20, 5),
                  p3(1, 1, 1), p3(0, 0, 0), 16'd0, 16'd0, 1'b0};
        tv[5] = '{3'b101, p3(10, -7, 100), p3(20, 3, 0),
                  p3(2, -3, 0), p3(-1, 4, -1), 16'd40, -16'sd70, 1'b0};
        tv[6] = '{3'b111, p3(-20000, -20000, -20000), p3(100, 100, 100),
                  p3(1, 1, 1), p3(0, 0, 0), 16'h8000, 16'd300, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_outputs", {y_valid, y_sat, y_r, y_i}, 64'h0);
        chk("rst_mult", {m_ce, m_ar, m_ai, m_br, m_bi}, 64'h0);
        step();

        for (int v = 0; v < 7; v++) begin
            run_symbol(v, 0, 0);
            repeat (v % 2) step();
        end

        run_symbol(0, 1, 3);
        run_symbol(3, 0, 0);

        run_symbol(5, 2, 0);

        drive(2);
        step();
        in_valid = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_outputs", {y_valid, y_sat, y_r, y_i}, 64'h0);
        chk("abort_m_ce", m_ce, 0);
        for (int c = 0; c < 8; c++) begin
            chk("abort_no_y_valid", y_valid, 0);
            step();
        end
        run_symbol(5, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
